// File: rtl/param_event_counter.sv
// param_event_counter
//   Multi-channel event counter with a single request/acknowledge readout port.
//   Each channel counts its inc_i strobe, either wrapping (with a sticky
//   overflow flag) or saturating at the maximum value. A read captures the
//   selected counter and its overflow flag into a holding register, which is
//   presented until the consumer acknowledges. Optionally, an accepted read
//   zeroes the selected channel.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   inc_i        per-channel increment strobe
//   clr_i        synchronous clear of all counters and overflow flags
//   rd_req_i     read request (accepted only in IDLE)
//   rd_sel_i     channel to read, sampled with rd_req_i
//   rd_ack_i     consumer acknowledge of presented data
//   rd_valid_o   rd_data_o / rd_ovf_o / rd_err_o valid
//   rd_data_o    captured counter value
//   rd_ovf_o     captured overflow flag
//   rd_err_o     requested channel does not exist
//   busy_o       FSM in PRESENT
//
// States
//   IDLE    | waiting for rd_req_i; next request is captured on the edge it is seen
//   PRESENT | captured data held on the read outputs until rd_ack_i
module param_event_counter #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter bit SATURATE      = 1'b0,
  parameter bit CLEAR_ON_READ = 1'b0,
  parameter int RESET_VALUE   = 0,
  localparam int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] inc_i,
  input  logic                clr_i,
  input  logic                rd_req_i,
  input  logic [SEL_W-1:0]    rd_sel_i,
  input  logic                rd_ack_i,
  output logic                rd_valid_o,
  output logic [WIDTH-1:0]    rd_data_o,
  output logic                rd_ovf_o,
  output logic                rd_err_o,
  output logic                busy_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  // One extra bit so CHANNELS itself is representable (e.g. 16 with SEL_W=4).
  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                rd_ovf_q, rd_ovf_d;
  logic                err_q, err_d;

  logic                accept;
  logic                sel_legal;
  logic                rd_clear;
  logic [SEL_W-1:0]    sel_idx;
  logic [WIDTH-1:0]    sel_cnt;
  logic                sel_ovf;

  // With a single channel the select input carries no information.
  assign sel_idx   = (CHANNELS == 1) ? '0 : rd_sel_i;
  assign sel_legal = (CHANNELS == 1) ? 1'b1 : ({1'b0, rd_sel_i} < CH_LIM);
  assign accept    = (state_q == IDLE) && rd_req_i;
  assign rd_clear  = CLEAR_ON_READ && accept && sel_legal;

  // Loop-based mux keeps out-of-range selects from indexing past the array.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_cnt = cnt_q[k];
        sel_ovf = ovf_q[k];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (clr_i) begin
        cnt_d[k] = CNT_RST;
        ovf_d[k] = 1'b0;
      end else if (rd_clear && (sel_idx == SEL_W'(k))) begin
        // Same-cycle increment is not lost: the cleared counter starts at 1.
        cnt_d[k] = inc_i[k] ? CNT_ONE : '0;
        ovf_d[k] = 1'b0;
      end else if (inc_i[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_d[k] = 1'b1;
          cnt_d[k] = SATURATE ? CNT_MAX : '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rd_ovf_d = rd_ovf_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          state_d  = PRESENT;
          data_d   = sel_legal ? sel_cnt : '0;
          rd_ovf_d = sel_legal & sel_ovf;
          err_d    = ~sel_legal;
        end
      end
      PRESENT: begin
        // Data and overflow stay on the bus after ack; only err is retired.
        if (rd_ack_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rd_ovf_q <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= CNT_RST;
      end
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rd_ovf_q <= rd_ovf_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_valid_o = (state_q == PRESENT);
  assign busy_o     = (state_q == PRESENT);
  assign rd_data_o  = data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign rd_err_o   = err_q;

endmodule

// File: tb/tb_param_event_counter.sv
// Directed bench for param_event_counter. Three instances share WIDTH=4,
// CHANNELS=3, RESET_VALUE=2 and differ in mode:
//   0: wrapping, no clear-on-read
//   1: saturating
//   2: wrapping, clear-on-read
module tb_param_event_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] inc_v   [3];
  logic       clr_v   [3];
  logic       req_v   [3];
  logic [1:0] sel_v   [3];
  logic       ack_v   [3];
  logic       valid_v [3];
  logic [3:0] data_v  [3];
  logic       ovf_v   [3];
  logic       err_v   [3];
  logic       busy_v  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    param_event_counter #(
      .WIDTH         (4),
      .CHANNELS      (3),
      .SATURATE      (g == 1),
      .CLEAR_ON_READ (g == 2),
      .RESET_VALUE   (2)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (inc_v[g]),
      .clr_i      (clr_v[g]),
      .rd_req_i   (req_v[g]),
      .rd_sel_i   (sel_v[g]),
      .rd_ack_i   (ack_v[g]),
      .rd_valid_o (valid_v[g]),
      .rd_data_o  (data_v[g]),
      .rd_ovf_o   (ovf_v[g]),
      .rd_err_o   (err_v[g]),
      .busy_o     (busy_v[g])
    );
  end

  task automatic check_val(input string tag, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full view of the read port of instance d.
  task automatic check_port(input int d, input string tag, input int e_valid,
                            input int e_data, input int e_ovf, input int e_err);
    check_val($sformatf("%s/d%0d/valid", tag, d), int'(valid_v[d]), e_valid);
    check_val($sformatf("%s/d%0d/busy",  tag, d), int'(busy_v[d]),  e_valid);
    check_val($sformatf("%s/d%0d/data",  tag, d), int'(data_v[d]),  e_data);
    check_val($sformatf("%s/d%0d/ovf",   tag, d), int'(ovf_v[d]),   e_ovf);
    check_val($sformatf("%s/d%0d/err",   tag, d), int'(err_v[d]),   e_err);
  endtask

  task automatic inc_n(input int d, input logic [2:0] mask, input int n);
    inc_v[d] = mask;
    repeat (n) tick();
    inc_v[d] = '0;
  endtask

  task automatic read_start(input int d, input logic [1:0] sel);
    req_v[d] = 1'b1;
    sel_v[d] = sel;
    tick();
    req_v[d] = 1'b0;
  endtask

  task automatic read_ack(input int d);
    ack_v[d] = 1'b1;
    tick();
    ack_v[d] = 1'b0;
  endtask

  // Complete read: accept, check presented values, acknowledge, check drop.
  task automatic read_chk(input int d, input string tag, input logic [1:0] sel,
                          input int e_data, input int e_ovf, input int e_err);
    read_start(d, sel);
    check_port(d, tag, 1, e_data, e_ovf, e_err);
    read_ack(d);
    check_port(d, {tag, "/ack"}, 0, e_data, e_ovf, 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      inc_v[d] = '0; clr_v[d] = 1'b0; req_v[d] = 1'b0;
      sel_v[d] = '0; ack_v[d] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    for (int d = 0; d < 3; d++) check_port(d, "reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Latency: not valid on the accept edge's input cycle, valid after it.
    req_v[0] = 1'b1; sel_v[0] = 2'd1;
    check_val("pre_accept/valid", int'(valid_v[0]), 0);
    tick();
    req_v[0] = 1'b0;
    check_port(0, "rd_ch1_reset", 1, 2, 0, 0);
    read_ack(0);
    check_port(0, "rd_ch1_reset/ack", 0, 2, 0, 0);

    // Ack while idle has no effect.
    ack_v[0] = 1'b1; tick(); ack_v[0] = 1'b0;
    check_val("idle_ack/valid", int'(valid_v[0]), 0);

    // Wrap: 2 + 15 = 17 -> 1, overflow; a plain read does not clear.
    inc_n(0, 3'b001, 15);
    read_chk(0, "wrap_ch0", 2'd0, 1, 1, 0);
    read_chk(0, "wrap_ch0_again", 2'd0, 1, 1, 0);

    // Saturate: 15 incs from 2 stick at 15 with overflow; further inc holds.
    inc_n(1, 3'b001, 15);
    read_chk(1, "sat_ch0", 2'd0, 15, 1, 0);
    inc_n(1, 3'b001, 1);
    read_chk(1, "sat_ch0_more", 2'd0, 15, 1, 0);

    // Clear-on-read: 19 incs from 2 -> 5 with overflow; read with same-cycle
    // inc presents 5, leaves 1; the next read leaves 0.
    inc_n(2, 3'b100, 19);
    req_v[2] = 1'b1; sel_v[2] = 2'd2; inc_v[2] = 3'b100;
    tick();
    req_v[2] = 1'b0; inc_v[2] = '0;
    check_port(2, "cor_first", 1, 5, 1, 0);
    read_ack(2);
    read_chk(2, "cor_second", 2'd2, 1, 0, 0);
    read_chk(2, "cor_third", 2'd2, 0, 0, 0);

    // Busy: ch0 of dut0 holds 1 with ovf. Request held with another select
    // and counting continues; presented data must not move, nor on clr.
    inc_n(0, 3'b010, 3);
    read_start(0, 2'd0);
    req_v[0] = 1'b1; sel_v[0] = 2'd1; inc_v[0] = 3'b011;
    tick();
    check_port(0, "busy_hold1", 1, 1, 1, 0);
    tick();
    check_port(0, "busy_hold2", 1, 1, 1, 0);
    inc_v[0] = '0; clr_v[0] = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    check_port(0, "busy_clr", 1, 1, 1, 0);
    // Request still asserted during the ack cycle: no back-to-back accept.
    sel_v[0] = 2'd0; ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    check_port(0, "ack_no_b2b", 0, 1, 1, 0);
    tick();
    req_v[0] = 1'b0;
    check_port(0, "after_clr_ch0", 1, 2, 0, 0);
    read_ack(0);
    read_chk(0, "after_clr_ch1", 2'd1, 2, 0, 0);

    // Illegal select: error, zero data, nothing disturbed.
    read_chk(0, "bad_sel", 2'd3, 0, 0, 1);
    read_chk(2, "bad_sel_cor", 2'd3, 0, 0, 1);
    read_chk(0, "post_bad_ch0", 2'd0, 2, 0, 0);

    // Reset while presenting: outputs drop without a clock edge.
    inc_n(0, 3'b001, 1);
    read_start(0, 2'd0);
    check_port(0, "pre_rst_read", 1, 3, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check_port(0, "async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    read_chk(0, "post_rst_d0", 2'd0, 2, 0, 0);
    read_chk(1, "post_rst_d1", 2'd0, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_event_counter.md
Name: param_event_counter

Overview:
- Multi-channel event counter; successor to the single-bit-parameter example module, generalised in width, channel count and mode.
- Exposes a mixed set of parameters (int, bit, localparam) so the VPI parameter-iteration examples walk a real design.
- Instantiated under top by the parameters examples.
- Counter readout goes through a one-channel request/acknowledge port.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- CHANNELS, 4, number of independent counters; legal range 1..16.
- SATURATE, 1'b0, bit. 1 = counters stick at max; 0 = counters wrap to 0.
- CLEAR_ON_READ, 1'b0, bit. 1 = an accepted read zeroes the selected counter and its overflow flag.
- RESET_VALUE, 0, counter value after reset and after clr_i; must be < 2**WIDTH.
- SEL_W, localparam, (CHANNELS > 1) ? $clog2(CHANNELS) : 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inc_i  input  CHANNELS  per-channel increment strobe, sampled each clk.
- clr_i  input  1  synchronous clear of all counters and overflow flags.
- rd_req_i  input  1  read request.
- rd_sel_i  input  SEL_W  channel to read; sampled with rd_req_i.
- rd_ack_i  input  1  consumer acknowledge of presented data.
- rd_valid_o  output  1  rd_data_o / rd_ovf_o / rd_err_o valid.
- rd_data_o  output  WIDTH  captured counter value.
- rd_ovf_o  output  1  captured overflow flag of the channel.
- rd_err_o  output  1  rd_sel_i was >= CHANNELS.
- busy_o  output  1  FSM in PRESENT state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All counters = RESET_VALUE; all ovf flags = 0.
  - FSM = IDLE.
  - rd_valid_o, rd_data_o, rd_ovf_o, rd_err_o, busy_o = 0.
  - Deassertion takes effect at the next clk edge.
- Counter update per channel k, per cycle, priority high to low:
  - clr_i: cnt = RESET_VALUE, ovf = 0.
  - Read-clear of k (see below).
  - inc_i[k]: increment.
- Increment rules:
  - cnt < 2**WIDTH-1: cnt + 1.
  - cnt == max, SATURATE=0: cnt = 0, ovf[k] = 1.
  - cnt == max, SATURATE=1: cnt holds at max, ovf[k] = 1.
  - ovf is sticky until clr_i, read-clear, or reset.
- FSM IDLE:
  - rd_req_i=1 is accepted on that edge.
  - Capture uses the registered cnt/ovf of rd_sel_i before that edge's update, i.e. excluding same-cycle inc.
  - Next state PRESENT; rd_valid_o=1 and busy_o=1 from the following cycle (latency 1).
- rd_sel_i >= CHANNELS:
  - rd_data_o=0, rd_ovf_o=0, rd_err_o=1.
  - No counter is affected.
- Read-clear (CLEAR_ON_READ=1, legal sel, at the accept edge):
  - cnt[sel] = 0, or 1 if inc_i[sel] is set that cycle.
  - ovf[sel] = 0.
  - clr_i still wins over read-clear.
- FSM PRESENT:
  - Outputs held stable; rd_req_i ignored.
  - Counters keep counting; clr_i does not alter presented data.
  - rd_ack_i=1 moves to IDLE; rd_valid_o, busy_o, rd_err_o drop next cycle.
  - rd_data_o and rd_ovf_o keep their last value.
  - A new request is accepted no earlier than the first cycle after returning to IDLE; no back-to-back accept in the ack cycle.
- rd_ack_i in IDLE: ignored.
- CHANNELS=1: rd_sel_i ignored; always channel 0, never rd_err_o.
- Parameter-check constraint: no parameter may be removed by elaboration. WIDTH, CHANNELS, SATURATE, CLEAR_ON_READ and RESET_VALUE must all be visible to vpi_iterate(vpiParameter, inst).

Test Plan:
- WIDTH=4, CHANNELS=3, RESET_VALUE=2:
  - Reset, then read ch1 → rd_valid_o one cycle after accept, rd_data_o=2, rd_ovf_o=0.
  - After rd_ack_i, rd_valid_o=0 next cycle.
- SATURATE=0, WIDTH=4: 15 incs on ch0 → read 1 (2+15 wraps past 15), ovf=1.
- SATURATE=1, same stimulus: 15 incs on ch0 → read 15, ovf=1; a further inc still reads 15.
- CLEAR_ON_READ=1:
  - Count ch2 to 5.
  - Read with inc_i[2]=1 on the accept cycle → presented 5; second read returns 1, ovf=0.
- Busy-state handling:
  - rd_req_i held while busy_o=1 → no re-capture, data stable.
  - clr_i while PRESENT → presented data unchanged; next read = RESET_VALUE.
  - rd_sel_i=3 with CHANNELS=3 → rd_err_o=1, rd_data_o=0.
- Reset mid-read:
  - Drop rst_n while PRESENT → rd_valid_o and busy_o go 0 immediately (no clk needed).
  - Counters read RESET_VALUE afterwards.
  - vpi_iterate(vpiParameter) on the instance lists exactly 5 parameters plus SEL_W.
